// File: rtl/code_unlock_ctrl.sv
// Serial code-entry lock controller: collects CODE_LEN bits, compares against a
// programmable code, and enforces an inter-bit timeout and a failure lockout.
module code_unlock_ctrl #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  TIMEOUT_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             ser_val,
    input  logic                             ser_data,
    input  logic                             code_wr,
    input  logic [CODE_LEN-1:0]              code_in,
    output logic                             output_val,
    output logic                             output_data,
    output logic                             locked_out,
    output logic                             busy,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int BW = $clog2(CODE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);

    localparam logic [BW-1:0] LAST_IDX = BW'(CODE_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_PASS,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [CODE_LEN-1:0] shreg_q, shreg_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [LW-1:0]       lk_cnt_q, lk_cnt_d;
    logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
    logic                out_val_q, out_val_d;
    logic                out_data_q, out_data_d;
    logic                locked_q, locked_d;
    logic                busy_q, busy_d;

    logic [CODE_LEN:0]   sh_ext;
    logic [CODE_LEN-1:0] sh_next;
    logic [FW-1:0]       fail_inc;
    logic                last_bit;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        lk_cnt_d   = lk_cnt_q;
        fail_cnt_d = fail_cnt_q;

        sh_ext   = {shreg_q, ser_data};
        sh_next  = sh_ext[CODE_LEN-1:0];
        fail_inc = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
        // bit_cnt is 0 in IDLE, so this also covers a single-bit code
        last_bit = (bit_cnt_q == LAST_IDX);

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_IDLE && code_wr) begin
                    code_d = code_in;
                end else if (ser_val) begin
                    tmo_cnt_d = '0;
                    if (last_bit) begin
                        state_d   = (sh_next == code_q) ? S_PASS : S_FAIL;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = S_COLLECT;
                        shreg_d   = sh_next;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (state_q == S_COLLECT) begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        state_d   = S_FAIL;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            S_PASS: begin
                fail_cnt_d = '0;
                state_d    = S_IDLE;
            end
            S_FAIL: begin
                fail_cnt_d = fail_inc;
                if (fail_inc == FAIL_MAX) begin
                    state_d  = S_LOCKOUT;
                    lk_cnt_d = LK_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (lk_cnt_q == '0) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    lk_cnt_d = lk_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
                tmo_cnt_d = '0;
                lk_cnt_d  = '0;
            end
        endcase

        out_val_d  = (state_d == S_PASS) || (state_d == S_FAIL);
        out_data_d = (state_d == S_PASS);
        locked_d   = (state_d == S_LOCKOUT);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            code_q     <= DEFAULT_CODE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            lk_cnt_q   <= '0;
            fail_cnt_q <= '0;
            out_val_q  <= 1'b0;
            out_data_q <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            lk_cnt_q   <= lk_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
        end
    end

    assign output_val  = out_val_q;
    assign output_data = out_data_q;
    assign locked_out  = locked_q;
    assign busy        = busy_q;
    assign fail_cnt    = fail_cnt_q;

endmodule
